sync_fifo_param: RTL and testbench

Single-clock, parametrised FIFO that replaces the earlier pulse-driven FIFO. It is used between the camera UART receive path and the JPEG frame store. It adds:
- a true clocked read/write handshake
- a selectable first-word-fall-through (FWFT) output mode
- programmable almost-full and almost-empty thresholds
- an occupancy count
- sticky overflow and underflow error flags

---
 rtl/sync_fifo_param.sv | 135 +++++++++++++
 tb/tb_sync_fifo_param.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with a clocked read/write handshake, selectable
// first-word-fall-through output, programmable almost-full/almost-empty thresholds,
// an occupancy count and sticky overflow/underflow flags.
module sync_fifo_param #(
  parameter int unsigned DATO_WIDTH  = 8,
  parameter int unsigned FIFO_LENGTH = 7,
  parameter int unsigned FWFT        = 0,
  parameter int unsigned AF_LEVEL    = (2 ** FIFO_LENGTH) - 2,
  parameter int unsigned AE_LEVEL    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DATO_WIDTH-1:0]  datin,
  input  logic                   rd_en,
  input  logic                   clr_err,
  output logic [DATO_WIDTH-1:0]  datout,
  output logic                   full,
  output logic                   empy,
  output logic                   dato,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [FIFO_LENGTH:0]   count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int unsigned Depth = 2 ** FIFO_LENGTH;
  localparam logic [FIFO_LENGTH:0]   DepthCnt = {1'b1, {FIFO_LENGTH{1'b0}}};
  localparam logic [FIFO_LENGTH:0]   CntOne   = {{FIFO_LENGTH{1'b0}}, 1'b1};
  localparam logic [FIFO_LENGTH-1:0] PtrOne   = {{(FIFO_LENGTH-1){1'b0}}, 1'b1};

  // Reject parameter sets the flag decode cannot honour.
  if (FIFO_LENGTH < 2 || FIFO_LENGTH > 10 || AF_LEVEL > Depth || AE_LEVEL >= AF_LEVEL)
  begin : g_param_check
    $error("sync_fifo_param: illegal parameter combination");
  end

  logic [DATO_WIDTH-1:0]  mem [Depth];
  logic [FIFO_LENGTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_LENGTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_LENGTH:0]   count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic                   underflow_q, underflow_d;
  logic                   wr_acc, rd_acc;
  logic                   empy_int, full_int;

  // Status decode from the registered count only, so flags never glitch on inputs.
  always_comb begin
    empy_int     = (count_q == '0);
    full_int     = (count_q == DepthCnt);
    empy         = empy_int;
    full         = full_int;
    dato         = !empy_int && !full_int;
    almost_full  = (32'(count_q) >= AF_LEVEL);
    almost_empty = (32'(count_q) <= AE_LEVEL);
    count        = count_q;
    overflow     = overflow_q;
    underflow    = underflow_q;
  end

  // Handshake and next-state: a full FIFO still takes a write if a read frees a slot.
  always_comb begin
    rd_acc      = rd_en && !empy_int;
    wr_acc      = wr_en && (!full_int || rd_acc);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + PtrOne;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PtrOne;

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase

    // A new error in the same cycle as clr_err wins over the clear.
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_en && !wr_acc) overflow_d  = 1'b1;
    if (rd_en && !rd_acc) underflow_d = 1'b1;
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= datin;
  end

  if (FWFT != 0) begin : g_fwft
    // Head word shown combinationally; forced to zero while empty.
    always_comb begin
      datout = empy_int ? '0 : mem[rd_ptr_q];
    end
  end else begin : g_std
    logic [DATO_WIDTH-1:0] dout_q;

    // Registered read: data appears one edge after an accepted read and then holds.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q <= '0;
      end else if (rd_acc) begin
        dout_q <= mem[rd_ptr_q];
      end
    end

    // Drive the registered read word out.
    always_comb begin
      datout = dout_q;
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: one standard-read and one FWFT instance, depth 8.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  // Standard-read instance signals
  logic       wr0 = 1'b0, rd0 = 1'b0, clr0 = 1'b0;
  logic [7:0] din0 = '0, dout0;
  logic       full0, empy0, dato0, af0, ae0, ovf0, unf0;
  logic [3:0] cnt0;

  // FWFT instance signals
  logic       wr1 = 1'b0, rd1 = 1'b0, clr1 = 1'b0;
  logic [7:0] din1 = '0, dout1;
  logic       full1, empy1, dato1, af1, ae1, ovf1, unf1;
  logic [3:0] cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATO_WIDTH(8), .FIFO_LENGTH(3), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr0), .datin(din0), .rd_en(rd0), .clr_err(clr0),
    .datout(dout0), .full(full0), .empy(empy0), .dato(dato0), .almost_full(af0),
    .almost_empty(ae0), .count(cnt0), .overflow(ovf0), .underflow(unf0)
  );

  sync_fifo_param #(.DATO_WIDTH(8), .FIFO_LENGTH(3), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr1), .datin(din1), .rd_en(rd1), .clr_err(clr1),
    .datout(dout1), .full(full1), .empy(empy1), .dato(dato1), .almost_full(af1),
    .almost_empty(ae1), .count(cnt1), .overflow(ovf1), .underflow(unf1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    repeat (2) tick();
    rst = 1'b0;
    check("rst_count", 32'(cnt0), 0);
    check("rst_empy",  32'(empy0), 1);
    check("rst_full",  32'(full0), 0);
    check("rst_dato",  32'(dato0), 0);
    check("rst_ae",    32'(ae0), 1);
    check("rst_af",    32'(af0), 0);
    check("rst_dout",  32'(dout0), 0);
    check("rst_ovf",   32'(ovf0), 0);
    check("rst_unf",   32'(unf0), 0);

    // 1: fill with 0x11..0x18, almost_full from the 6th write
    for (int i = 0; i < 8; i++) begin
      wr0 = 1'b1; din0 = 8'(8'h11 + i);
      tick();
      check("fill_count", 32'(cnt0), 32'(i + 1));
      check("fill_af",    32'(af0), (i + 1 >= 6) ? 1 : 0);
    end
    wr0 = 1'b0;
    check("fill_full", 32'(full0), 1);
    check("fill_dato", 32'(dato0), 0);
    check("fill_ae",   32'(ae0), 0);
    for (int i = 0; i < 8; i++) begin
      rd0 = 1'b1;
      tick();
      check("drain_dout", 32'(dout0), 32'(8'h11 + i));
    end
    rd0 = 1'b0;
    check("drain_empy",  32'(empy0), 1);
    check("drain_count", 32'(cnt0), 0);

    // 2: overflow on full, oldest word preserved, clr_err clears
    for (int i = 0; i < 8; i++) begin
      wr0 = 1'b1; din0 = 8'(8'h21 + i);
      tick();
    end
    din0 = 8'hAA;
    tick();
    wr0 = 1'b0;
    check("ovf_set",   32'(ovf0), 1);
    check("ovf_count", 32'(cnt0), 8);
    rd0 = 1'b1;
    tick();
    rd0 = 1'b0;
    check("ovf_oldest", 32'(dout0), 'h21);
    check("ovf_sticky", 32'(ovf0), 1);
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    check("ovf_clr",  32'(ovf0), 0);
    wr0 = 1'b1; din0 = 8'h29;
    tick();
    wr0 = 1'b0;
    check("refill_full", 32'(full0), 1);

    // 3: simultaneous read/write while full; FIFO holds 0x22..0x29
    wr0 = 1'b1; rd0 = 1'b1; din0 = 8'h5C;
    tick();
    wr0 = 1'b0; rd0 = 1'b0;
    check("rw_full_dout",  32'(dout0), 'h22);
    check("rw_full_count", 32'(cnt0), 8);
    check("rw_full_full",  32'(full0), 1);
    check("rw_full_ovf",   32'(ovf0), 0);
    for (int i = 0; i < 8; i++) begin
      rd0 = 1'b1;
      tick();
      check("rw_drain", 32'(dout0), (i == 7) ? 'h5C : 32'(8'h23 + i));
    end
    rd0 = 1'b0;
    check("rw_empy", 32'(empy0), 1);

    // 4: simultaneous read/write while empty: write only, underflow set
    wr0 = 1'b1; rd0 = 1'b1; din0 = 8'h3D;
    tick();
    wr0 = 1'b0; rd0 = 1'b0;
    check("unf_set",   32'(unf0), 1);
    check("unf_count", 32'(cnt0), 1);
    check("unf_dout",  32'(dout0), 'h5C);
    rd0 = 1'b1;
    tick();
    check("unf_read", 32'(dout0), 'h3D);
    clr0 = 1'b1;   // empty again: new underflow must beat the clear
    tick();
    rd0 = 1'b0;
    check("unf_setwins", 32'(unf0), 1);
    tick();
    clr0 = 1'b0;
    check("unf_clr", 32'(unf0), 0);

    // 5: FWFT head visible without a read request
    check("fw_rst_empy", 32'(empy1), 1);
    wr1 = 1'b1; din1 = 8'h42;
    tick();
    wr1 = 1'b0;
    check("fw_dout",  32'(dout1), 'h42);
    check("fw_count", 32'(cnt1), 1);
    tick();
    check("fw_hold", 32'(dout1), 'h42);
    rd1 = 1'b1;
    tick();
    rd1 = 1'b0;
    check("fw_pop_empy",  32'(empy1), 1);
    check("fw_pop_count", 32'(cnt1), 0);
    wr1 = 1'b1; din1 = 8'h43;
    tick();
    din1 = 8'h44;
    tick();
    wr1 = 1'b0;
    check("fw_head1", 32'(dout1), 'h43);
    rd1 = 1'b1;
    tick();
    rd1 = 1'b0;
    check("fw_head2", 32'(dout1), 'h44);

    // 6: 20 cycles of writes, reads from cycle 5, pointers wrap; then async reset
    for (int k = 0; k < 20; k++) begin
      wr0 = 1'b1; din0 = 8'(8'h60 + k); rd0 = (k >= 5);
      tick();
      if (k >= 5) check("wrap_dout", 32'(dout0), 32'(8'h60 + k - 5));
    end
    wr0 = 1'b0; rd0 = 1'b0;
    check("wrap_count", 32'(cnt0), 5);
    #3;
    rst = 1'b1;
    #1;
    check("arst_count", 32'(cnt0), 0);
    check("arst_empy",  32'(empy0), 1);
    check("arst_dout",  32'(dout0), 0);
    check("arst_fw_cnt", 32'(cnt1), 0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_empy", 32'(empy0), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
